// File: rtl/uart_pkg.sv
// Shared constants and the receiver state encoding for the UART receive path.
package uart_pkg;

   // Default system clock and line rate.
   localparam int unsigned DEF_CLK_FREQ     = 100_000_000;
   localparam int unsigned DEF_BAUD         = 9600;

   // Derived bit timing at the default rates (integer division, truncated).
   localparam int unsigned DEF_CLKS_PER_BIT = DEF_CLK_FREQ / DEF_BAUD;
   localparam int unsigned DEF_HALF_BIT     = DEF_CLKS_PER_BIT / 2;

   // Receiver FSM encoding, 3 bits.
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_STOP      = 3'd3,
      ST_WAIT_IDLE = 3'd4
   } rx_state_e;

   // Width of a counter that must reach n-1; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      int unsigned w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/uart_rx_byte_if.sv
// Byte handshake between the UART receiver and the LCD sequencer.
interface uart_rx_byte_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;

   // Receiver side drives data/valid, sequencer drives ready.
   modport master (output rx_data, output rx_valid, input rx_ready);
   modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs (RXD, buttons).
module sync_2ff #(
   parameter bit RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   // First flop may go metastable; the second gives it a full cycle to settle.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking (<=) so every flop sees pre-edge values.
      if (reset) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with a one-entry holding register and valid/ready output.
module uart_rx_byte
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ     = DEF_CLK_FREQ,
   parameter int unsigned BAUD         = DEF_BAUD,
   parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             RXD,
   uart_rx_byte_if.master   rx_if,
   output logic             frame_err,
   output logic             overrun
);

   localparam int unsigned    CW       = cnt_width(CLKS_PER_BIT);
   localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]  CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

   logic          rxs;
   rx_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shreg_q, shreg_d;
   logic [7:0]    data_q, data_d;
   logic          valid_q, valid_d;
   logic          ferr_q, ferr_d;
   logic          ovr_q, ovr_d;
   logic          byte_done;

   sync_2ff #(.RESET_VAL(1'b1)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (RXD),
      .q     (rxs)
   );

   // Frame sequencing plus holding-register update for the next cycle.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch behind.
      state_d   = state_q;
      cnt_d     = cnt_q + CW'(1);
      idx_d     = idx_q;
      shreg_d   = shreg_q;
      data_d    = data_q;
      valid_d   = valid_q;
      ferr_d    = 1'b0;
      ovr_d     = 1'b0;
      byte_done = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (!rxs) state_d = ST_START;
         end
         ST_START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d   = '0;
               idx_d   = 3'd0;
               // A start bit that is high again at mid-bit was a glitch.
               state_d = rxs ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d          = '0;
               shreg_d[idx_q] = rxs;
               idx_d          = idx_q + 3'd1;
               if (idx_q == 3'd7) state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (rxs) begin
                  byte_done = 1'b1;
                  state_d   = ST_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = ST_WAIT_IDLE;
               end
            end
         end
         ST_WAIT_IDLE: begin
            // Hold off until the line returns high so a break cannot look like a start.
            cnt_d = '0;
            if (rxs) state_d = ST_IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase

      // A completed byte wins over a plain accept; a full, unaccepted register drops it.
      if (byte_done) begin
         if (!valid_q || rx_if.rx_ready) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (valid_q && rx_if.rx_ready) begin
         valid_d = 1'b0;
      end
   end

   // All receiver state and registered outputs, synchronously reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= 3'd0;
         shreg_q <= 8'h00;
         data_q  <= 8'h00;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
      end
   end

   assign rx_if.rx_data  = data_q;
   assign rx_if.rx_valid = valid_q;
   assign frame_err      = ferr_q;
   assign overrun        = ovr_q;

endmodule
